// File: rtl/kianv_clint_pkg.sv
// Shared CLINT register offsets, bus FSM states, reset constants and decode helpers.
// Pure definitions; no timing or flow-control behaviour lives here.
package kianv_clint_pkg;

  localparam logic [15:0] MSIP_OFFS        = 16'h0000;
  localparam logic [15:0] MTIMECMP_LO_OFFS = 16'h4000;
  localparam logic [15:0] MTIMECMP_HI_OFFS = 16'h4004;
  localparam logic [15:0] MTIME_LO_OFFS    = 16'hBFF8;
  localparam logic [15:0] MTIME_HI_OFFS    = 16'hBFFC;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_ACK  = 1'b1;

  localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_MSIP,
    SEL_MTIMECMP_LO,
    SEL_MTIMECMP_HI,
    SEL_MTIME_LO,
    SEL_MTIME_HI
  } reg_sel_e;

  // Word-granular decode: the two byte-offset bits never reach this function.
  function automatic reg_sel_e decode_reg(input logic [13:0] word);
    reg_sel_e sel;
    sel = SEL_NONE;
    case (word)
      MSIP_OFFS[15:2]:        sel = SEL_MSIP;
      MTIMECMP_LO_OFFS[15:2]: sel = SEL_MTIMECMP_LO;
      MTIMECMP_HI_OFFS[15:2]: sel = SEL_MTIMECMP_HI;
      MTIME_LO_OFFS[15:2]:    sel = SEL_MTIME_LO;
      MTIME_HI_OFFS[15:2]:    sel = SEL_MTIME_HI;
      default:                sel = SEL_NONE;
    endcase
    return sel;
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/clint_timer_if.sv
// Register bus between the system decoder and the CLINT timer.
// Requester holds valid/addr/wstrb/wdata until it sees ready for one cycle.
interface clint_timer_if;
  logic        valid;
  logic        ready;
  logic [15:0] addr;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output valid, addr, wstrb, wdata, input ready, rdata);
  modport slave  (input valid, addr, wstrb, wdata, output ready, rdata);
endinterface

// File: rtl/tick_prescaler.sv
// Divides clk by TICK_DIV into a one-cycle tick; tick is combinational from the count.
// No backpressure; clear restarts the count at 0 on the next cycle.
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear,
  output logic tick
);
  localparam logic [15:0] LAST = 16'(TICK_DIV - 1);

  logic [15:0] cnt_q, cnt_d;

  assign tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + 16'd1;
    if (clear || tick) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/clint_timer.sv
// RISC-V CLINT: msip, mtimecmp and a prescaled 64-bit mtime behind a simple register bus.
// Every request is acked exactly one cycle after valid; an idle cycle always follows each ack.
module clint_timer
  import kianv_clint_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic         clk,
  input  logic         resetn,
  clint_timer_if.slave bus,
  output logic         IRQ3,
  output logic         IRQ7,
  output logic [63:0]  mtime_o
);

  logic [0:0]  state_q, state_d;
  logic [31:0] rdata_q, rdata_d;
  logic        msip_q, msip_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic [63:0] mtime_q, mtime_d;
  logic        irq7_q, irq7_d;

  reg_sel_e    sel;
  logic        tick;
  logic        wr_en;
  logic        mtime_wr;
  logic [31:0] rd_val;
  logic        addr_unused;

  assign sel         = decode_reg(bus.addr[15:2]);
  assign addr_unused = ^bus.addr[1:0];
  assign wr_en       = (state_q == ST_ACK) && bus.valid && (bus.wstrb != 4'b0000);
  assign mtime_wr    = wr_en && ((sel == SEL_MTIME_LO) || (sel == SEL_MTIME_HI));

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .resetn(resetn),
    .clear (mtime_wr),
    .tick  (tick)
  );

  always_comb begin
    rd_val = '0;
    case (sel)
      SEL_MSIP:        rd_val = {31'd0, msip_q};
      SEL_MTIMECMP_LO: rd_val = mtimecmp_q[31:0];
      SEL_MTIMECMP_HI: rd_val = mtimecmp_q[63:32];
      SEL_MTIME_LO:    rd_val = mtime_q[31:0];
      SEL_MTIME_HI:    rd_val = mtime_q[63:32];
      default:         rd_val = '0;
    endcase
  end

  // Read data is captured on entry to ACK so it reflects the pre-write register.
  always_comb begin
    state_d = ST_IDLE;
    rdata_d = '0;
    if (state_q == ST_IDLE && bus.valid) begin
      state_d = ST_ACK;
      rdata_d = rd_val;
    end
  end

  // A write to one mtime half freezes the other half, so no carry crosses the written word.
  always_comb begin
    msip_d     = msip_q;
    mtimecmp_d = mtimecmp_q;
    mtime_d    = mtime_q + {63'd0, tick};
    irq7_d     = (mtime_q >= mtimecmp_q);
    if (wr_en) begin
      case (sel)
        SEL_MSIP:        if (bus.wstrb[0]) msip_d = bus.wdata[0];
        SEL_MTIMECMP_LO: mtimecmp_d[31:0]  = merge_bytes(mtimecmp_q[31:0], bus.wdata, bus.wstrb);
        SEL_MTIMECMP_HI: mtimecmp_d[63:32] = merge_bytes(mtimecmp_q[63:32], bus.wdata, bus.wstrb);
        SEL_MTIME_LO:    mtime_d = {mtime_q[63:32], merge_bytes(mtime_q[31:0], bus.wdata, bus.wstrb)};
        SEL_MTIME_HI:    mtime_d = {merge_bytes(mtime_q[63:32], bus.wdata, bus.wstrb), mtime_q[31:0]};
        default:         ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      rdata_q    <= '0;
      msip_q     <= 1'b0;
      mtimecmp_q <= MTIMECMP_RST;
      mtime_q    <= '0;
      irq7_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rdata_q    <= rdata_d;
      msip_q     <= msip_d;
      mtimecmp_q <= mtimecmp_d;
      mtime_q    <= mtime_d;
      irq7_q     <= irq7_d;
    end
  end

  assign bus.ready = (state_q == ST_ACK);
  assign bus.rdata = rdata_q;
  assign IRQ3      = msip_q;
  assign IRQ7      = irq7_q;
  assign mtime_o   = mtime_q;

endmodule

// File: doc/clint_timer.md
CLINT_TIMER -- requirements
Module: clint_timer

Interface
- REQ-001: Parameter TICK_DIV, default 1: number of clk cycles per mtime increment; legal values are 1..65535.
- REQ-002: clk  input  1  system clock; all state is updated on the rising edge.
- REQ-003: resetn  input  1  reset, asynchronous and active-low.
- REQ-004: valid  input  1  bus request; the external decoder has already selected this block.
- REQ-005: ready  output  1  single-cycle acknowledge of the current request.
- REQ-006: addr  input  16  byte offset inside the block; bits [1:0] are ignored.
- REQ-007: wstrb  input  4  byte write enables; a value of 0 marks the request as a read.
- REQ-008: wdata  input  32  write data.
- REQ-009: rdata  output  32  read data; valid while ready=1 and 0 otherwise.
- REQ-010: IRQ3  output  1  machine software interrupt (MSIP), feeds the mip.MSIP input of the CSR unit.
- REQ-011: IRQ7  output  1  machine timer interrupt (MTIP), feeds the mip.MTIP input of the CSR unit.
- REQ-012: mtime_o  output  64  current mtime value, the source for the time/timeh CSR reads.

Function
- REQ-013: Register map:
  - 0x0000 msip: bit 0 is read/write; bits [31:1] read 0.
  - 0x4000 mtimecmp[31:0]; 0x4004 mtimecmp[63:32].
  - 0xBFF8 mtime[31:0]; 0xBFFC mtime[63:32].
- REQ-014: The bus handshake is a two-state FSM:
  - IDLE -> ACK when valid=1 and ready=0.
  - ACK drives ready=1 for exactly one cycle, then returns to IDLE.
- REQ-015: Request latency from valid to ready is 1 cycle.
- REQ-016: After an ACK, the block does not accept a new request until at least one IDLE cycle has passed.
- REQ-017: A write takes effect in the ACK cycle; the new value is visible from the next cycle.
- REQ-018: Each byte lane n is written only when wstrb[n]=1.
- REQ-019: rdata is registered on entry to ACK and holds the pre-write value of the addressed register.
- REQ-020: An unmapped offset is still acknowledged; it reads 0 and writes to it are ignored.
- REQ-021: The prescaler counts 0..TICK_DIV-1 and pulses tick when the count equals TICK_DIV-1, then wraps to 0.
- REQ-022: When TICK_DIV=1, tick is asserted every cycle.
- REQ-023: On tick, mtime increments by 1 modulo 2^64; a carry out of the low word propagates into the high word in the same cycle.
- REQ-024: If a bus write to either mtime half coincides with tick, the written value wins for the written bytes.
  - The other half keeps its pre-increment value, so there is no carry into or out of the written half.
- REQ-025: A write to either mtime half clears the prescaler to 0.
- REQ-026: IRQ7 is registered: IRQ7 <= (mtime >= mtimecmp), unsigned 64-bit compare using the current register values.
  - This gives 1 cycle of latency after mtime or mtimecmp changes.
- REQ-027: IRQ7 stays asserted until software raises mtimecmp above mtime or writes mtime below mtimecmp.
- REQ-028: IRQ3 equals the msip bit directly from its register, with no additional latency.
- REQ-029: mtime_o equals the mtime register.
- REQ-030: When mtime wraps from 2^64-1 to 0, IRQ7 follows the compare rule with no special casing.

Reset
- REQ-031: On resetn=0, all of the following are asynchronously forced: FSM = IDLE, ready = 0, rdata = 0, msip = 0, IRQ3 = 0, IRQ7 = 0, mtime = 0, prescaler = 0, mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF.
- REQ-032: Reset asserted during ACK aborts the transaction and discards its write.
- REQ-033: After reset is released, the first valid request is acknowledged 1 cycle later.

Structure
- REQ-034: The offsets (MSIP, MTIMECMP_LO/HI, MTIME_LO/HI), the FSM state enum, and the mtimecmp reset constant belong in the shared package kianv_clint_pkg.
- REQ-035: The prescaler is the one natural sub-module: tick_prescaler, parameterised by TICK_DIV, with ports clk, resetn, clear and tick.
- REQ-036: All other logic stays in clint_timer.

Verification
- REQ-037: Reset, then read 0x4004 and 0x4000 -> both return 32'hFFFFFFFF; IRQ7 stays 0.
- REQ-038: With TICK_DIV=4, write mtimecmp = 10 (write high word 0 first, then low word), leave mtime free-running from 0 -> IRQ7 rises exactly one cycle after mtime reaches 10 (about 40 cycles); then write mtimecmp_lo = 100 -> IRQ7 falls one cycle later.
- REQ-039: Write 0x0000 with wdata=1 and wstrb=4'b0001 -> IRQ3=1 in the cycle after ACK; write 0 -> IRQ3=0; write wdata=1 with wstrb=0 -> IRQ3 unchanged and read returns the old value.
- REQ-040: Write mtime_lo = 32'hFFFFFFFF and mtime_hi = 0, with TICK_DIV=1 -> on the next tick mtime = 64'h0000_0001_0000_0000.
- REQ-041: Write mtime_lo = 5 in a cycle where tick=1 -> mtime_o[31:0] = 5 with no increment, and the prescaler restarts from 0.
- REQ-042: Read unmapped offset 0x1234 -> ready after 1 cycle with rdata = 0; back-to-back valid requests -> ready is never asserted on two consecutive cycles.
